int2float_pipe: RTL

INT2FLOAT_PIPE -- requirements
Module: int2float_pipe

---
 rtl/int2float_pkg.sv | 22 ++
 rtl/int2float_lod.sv | 29 ++
 rtl/int2float_pipe.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/int2float_pkg.sv
// Shared types and elaboration helpers for the integer-to-float converter.
//   rnd_mode_e : rounding mode captured alongside each input word
//   widths_ok  : true when IN_W/MAN_W/EXP_W form a legal, fully representable
//                combination (every exponent the shifter can produce fits
//                in the output exponent field)
package int2float_pkg;

   typedef enum logic {
      RND_TRUNC = 1'b0,
      RND_RNE   = 1'b1
   } rnd_mode_e;

   function automatic bit widths_ok(input int in_w, input int man_w, input int exp_w);
      return (in_w >= 2) &&
             (man_w >= 2) &&
             (man_w <= in_w) &&
             (exp_w >= 1) &&
             (exp_w < 31) &&
             (((1 << exp_w) - 1) >= (in_w - man_w));
   endfunction

endpackage

// File: rtl/int2float_lod.sv
// Leading-one detector, purely combinational.
//   vec  : IN_W-bit magnitude
//   idx  : bit index of the most significant set bit (0 when vec is zero)
//   zero : 1 when vec has no bit set
module int2float_lod
   import int2float_pkg::*;
#(
   parameter int IN_W = 11
) (
   input  logic [IN_W-1:0]         vec,
   output logic [$clog2(IN_W)-1:0] idx,
   output logic                    zero
);

   localparam int IDX_W = $clog2(IN_W);

   // Ascending scan: the last set bit visited is the most significant one.
   always_comb begin
      idx  = '0;
      zero = 1'b1;
      for (int i = 0; i < IN_W; i++) begin
         if (vec[i]) begin
            idx  = IDX_W'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/int2float_pipe.sv
// Three-stage integer to small floating-point converter.
//   value = out_man * 2^out_exp, explicit leading one (no hidden bit).
//   S1 : capture input, sign and magnitude
//   S2 : leading-one detect, normalising right shift, guard/sticky extraction
//   S3 : round (truncate or nearest-even), saturate, output register
// Ports:
//   clk, rst              clock / asynchronous active-high reset
//   in_valid, in_ready    input handshake (in_ready = pipeline advance)
//   in_data, rnd_mode     integer to convert and its rounding mode
//   out_valid, out_ready  output handshake
//   out_sign/man/exp/ovf  converted result; out_ovf marks a saturated result
//   ovf_clr, ovf_sticky   sticky record of any saturated result leaving the block
module int2float_pipe
   import int2float_pkg::*;
#(
   parameter int IN_W   = 11,
   parameter int MAN_W  = 4,
   parameter int EXP_W  = 3,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             rnd_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [MAN_W-1:0] out_man,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_ovf,
   input  logic             ovf_clr,
   output logic             ovf_sticky
);

   localparam int IDX_W   = $clog2(IN_W);
   // Internal exponent carries one extra value so a rounding carry past the
   // largest shift is still visible to the saturation compare.
   localparam int EXPI_W  = $clog2(IN_W + 1);
   localparam int EXP_MAX = (1 << EXP_W) - 1;

   if (!widths_ok(IN_W, MAN_W, EXP_W)) begin : g_bad_widths
      $error("int2float_pipe: exponent field too narrow for IN_W/MAN_W");
   end

   logic adv;

   // S1 signals
   logic            sign_s0;
   logic [IN_W-1:0] mag_s0;
   logic            v1;
   logic            sign1;
   logic [IN_W-1:0] mag1;
   rnd_mode_e       rnd1;

   // S2 signals
   logic [IDX_W-1:0]  lod_idx;
   logic              lod_zero;
   logic [MAN_W-1:0]  man_s1;
   logic [EXPI_W-1:0] exp_s1;
   logic              guard_s1;
   logic              sticky_s1;
   logic              v2;
   logic              sign2;
   rnd_mode_e         rnd2;
   logic [MAN_W-1:0]  man2;
   logic [EXPI_W-1:0] exp2;
   logic              guard2;
   logic              sticky2;

   // S3 signals
   logic              round_up;
   logic [MAN_W:0]    man_sum;
   logic [MAN_W-1:0]  man_r;
   logic [EXPI_W-1:0] exp_r;
   logic [EXP_W-1:0]  exp_o;
   logic              ovf_r;

   // Whole pipeline moves as one; bubbles are carried, not squeezed out.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // ---------------- S1: sign / magnitude ----------------
   // Negating the most-negative value wraps to 2^(IN_W-1), which read as an
   // unsigned IN_W-bit magnitude is exactly right.
   always_comb begin
      sign_s0 = 1'b0;
      mag_s0  = in_data;
      if ((SIGNED != 0) && in_data[IN_W-1]) begin
         sign_s0 = 1'b1;
         mag_s0  = -in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         sign1 <= 1'b0;
         mag1  <= '0;
         rnd1  <= RND_TRUNC;
      end else if (adv) begin
         v1    <= in_valid;
         sign1 <= sign_s0;
         mag1  <= mag_s0;
         rnd1  <= rnd_mode_e'(rnd_mode);
      end
   end

   // ---------------- S2: normalise ----------------
   int2float_lod #(
      .IN_W (IN_W)
   ) u_lod (
      .vec  (mag1),
      .idx  (lod_idx),
      .zero (lod_zero)
   );

   // Shift so the leading one lands in the mantissa MSB; values narrower
   // than the mantissa are left unshifted (exact). The first discarded bit
   // is the guard, everything below it ORs into sticky.
   always_comb begin
      int p;
      int e;
      p = int'(lod_idx);
      e = 0;
      if (!lod_zero && (p >= MAN_W)) begin
         e = p - MAN_W + 1;
      end
      man_s1    = MAN_W'(mag1 >> e);
      exp_s1    = EXPI_W'(e);
      guard_s1  = 1'b0;
      sticky_s1 = 1'b0;
      for (int i = 0; i < IN_W; i++) begin
         if (i == e - 1) begin
            guard_s1 = mag1[i];
         end else if (i < e - 1) begin
            sticky_s1 = sticky_s1 | mag1[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2      <= 1'b0;
         sign2   <= 1'b0;
         rnd2    <= RND_TRUNC;
         man2    <= '0;
         exp2    <= '0;
         guard2  <= 1'b0;
         sticky2 <= 1'b0;
      end else if (adv) begin
         v2      <= v1;
         sign2   <= sign1;
         rnd2    <= rnd1;
         man2    <= man_s1;
         exp2    <= exp_s1;
         guard2  <= guard_s1;
         sticky2 <= sticky_s1;
      end
   end

   // ---------------- S3: round / saturate ----------------
   // Nearest-even: round up when above half, or exactly half with odd mantissa.
   always_comb begin
      round_up = (rnd2 == RND_RNE) & guard2 & (sticky2 | man2[0]);
      man_sum  = {1'b0, man2} + {{MAN_W{1'b0}}, round_up};
      man_r    = man_sum[MAN_W-1:0];
      exp_r    = exp2;
      ovf_r    = 1'b0;
      if (man_sum[MAN_W]) begin
         // Carry out of the mantissa: renormalise by one position.
         man_r = {1'b1, {(MAN_W-1){1'b0}}};
         exp_r = exp2 + EXPI_W'(1);
      end
      exp_o = EXP_W'(exp_r);
      if (int'(exp_r) > EXP_MAX) begin
         man_r = '1;
         exp_o = '1;
         ovf_r = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_man   <= '0;
         out_exp   <= '0;
         out_ovf   <= 1'b0;
      end else if (adv) begin
         out_valid <= v2;
         out_sign  <= sign2;
         out_man   <= man_r;
         out_exp   <= exp_o;
         out_ovf   <= ovf_r;
      end
   end

   // Set has priority so a clear issued the same cycle never hides an overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && out_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule
